sram_arbiter: RTL and testbench

//   Shares the single external async SRAM (8-bit data, 20-bit address) between two requesters:
//   the CPU bus port and a DMA/secondary port (video fetch, blitter).

---
 rtl/sram_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external async SRAM: grants CPU or DMA, then sequences
// address setup -> strobe -> release and returns data and a one-cycle ack to the owner.
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int ACCESS_CYCLES = 2,
    parameter int ARB_MODE      = 0
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iCpuReq,
    input  logic              iCpuWr,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [7:0]        iCpuData,
    output logic              oCpuAck,
    output logic [7:0]        oCpuData,
    input  logic              iDmaReq,
    input  logic              iDmaWr,
    input  logic [ADDR_W-1:0] iDmaAddr,
    input  logic [7:0]        iDmaData,
    output logic              oDmaAck,
    output logic [7:0]        oDmaData,
    output logic [ADDR_W-1:0] oSramAddr,
    output logic [7:0]        oSramData,
    input  logic [7:0]        iSramData,
    output logic              oSramDir,
    output logic              oSramOe,
    output logic              oSramWe,
    output logic              oSramCe1,
    output logic              oBusy
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ownerDma_q, ownerDma_d;
    logic              wr_q, wr_d;
    logic              lastDma_q, lastDma_d;
    logic [ADDR_W-1:0] sramAddr_q, sramAddr_d;
    logic [7:0]        sramData_q, sramData_d;
    logic [7:0]        cpuData_q, cpuData_d;
    logic [7:0]        dmaData_q, dmaData_d;
    logic              grantDma;
    logic              inAccess;

    // lastDma resets high so the CPU wins the first contested round-robin grant
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ownerDma_q <= 1'b0;
            wr_q       <= 1'b0;
            lastDma_q  <= 1'b1;
            sramAddr_q <= '0;
            sramData_q <= '0;
            cpuData_q  <= '0;
            dmaData_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ownerDma_q <= ownerDma_d;
            wr_q       <= wr_d;
            lastDma_q  <= lastDma_d;
            sramAddr_q <= sramAddr_d;
            sramData_q <= sramData_d;
            cpuData_q  <= cpuData_d;
            dmaData_q  <= dmaData_d;
        end
    end

    always_comb begin
        grantDma = iDmaReq && (!iCpuReq || ((ARB_MODE == 1) && !lastDma_q));
    end

    // Port inputs are latched at the grant edge; cnt counts ACCESS cycles down to 1
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ownerDma_d = ownerDma_q;
        wr_d       = wr_q;
        lastDma_d  = lastDma_q;
        sramAddr_d = sramAddr_q;
        sramData_d = sramData_q;
        cpuData_d  = cpuData_q;
        dmaData_d  = dmaData_q;
        case (state_q)
            IDLE: begin
                if (iCpuReq || iDmaReq) begin
                    state_d    = ACCESS;
                    cnt_d      = CNT_W'(ACCESS_CYCLES);
                    ownerDma_d = grantDma;
                    lastDma_d  = grantDma;
                    wr_d       = grantDma ? iDmaWr   : iCpuWr;
                    sramAddr_d = grantDma ? iDmaAddr : iCpuAddr;
                    sramData_d = grantDma ? iDmaData : iCpuData;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        if (ownerDma_q) dmaData_d = iSramData;
                        else            cpuData_d = iSramData;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write strobe skips the first ACCESS cycle to give address/data setup time
    always_comb begin
        inAccess = (state_q == ACCESS);
        oSramCe1 = !inAccess;
        oSramOe  = !(inAccess && !wr_q);
        oSramWe  = !(inAccess && wr_q && (cnt_q != CNT_W'(ACCESS_CYCLES)));
        oSramDir = wr_q && (state_q != IDLE);
        oCpuAck  = (state_q == DONE) && !ownerDma_q;
        oDmaAck  = (state_q == DONE) && ownerDma_q;
        oBusy    = (state_q != IDLE);
    end

    assign oSramAddr = sramAddr_q;
    assign oSramData = sramData_q;
    assign oCpuData  = cpuData_q;
    assign oDmaData  = dmaData_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one fixed-priority and one round-robin instance
// share the port stimulus; each has its own behavioural SRAM.
module tb_sram_arbiter;

    localparam logic [19:0] CA = 20'h12345;
    localparam logic [6:0] P_IDLE    = 7'b1110000;
    localparam logic [6:0] P_RD      = 7'b0100001;
    localparam logic [6:0] P_WSET    = 7'b1101001;
    localparam logic [6:0] P_WSTB    = 7'b1001001;
    localparam logic [6:0] P_CDONE_R = 7'b1110101;
    localparam logic [6:0] P_CDONE_W = 7'b1111101;
    localparam logic [6:0] P_DDONE_W = 7'b1111011;
    localparam logic [6:0] P_DDONE_R = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        iReset;
    logic        cpuReq, cpuWr, dmaReq, dmaWr;
    logic [19:0] cpuAddr, dmaAddr;
    logic [7:0]  cpuData, dmaData;

    logic        fCpuAck, fDmaAck, fDir, fOe, fWe, fCe, fBusy;
    logic [7:0]  fCpuData, fDmaData, fWData, fRd;
    logic [19:0] fAddr;
    logic        rCpuAck, rDmaAck, rDir, rOe, rWe, rCe, rBusy;
    logic [7:0]  rCpuData, rDmaData, rWData, rRd;
    logic [19:0] rAddr;

    logic [7:0] memF [0:4095];
    logic [7:0] memR [0:4095];

    wire [6:0] fPins = {fOe, fWe, fCe, fDir, fCpuAck, fDmaAck, fBusy};
    wire [6:0] rPins = {rOe, rWe, rCe, rDir, rCpuAck, rDmaAck, rBusy};

    sram_arbiter #(.ADDR_W(20), .ACCESS_CYCLES(2), .ARB_MODE(0)) u_fixed (
        .iClk(clk), .iReset(iReset),
        .iCpuReq(cpuReq), .iCpuWr(cpuWr), .iCpuAddr(cpuAddr), .iCpuData(cpuData),
        .oCpuAck(fCpuAck), .oCpuData(fCpuData),
        .iDmaReq(dmaReq), .iDmaWr(dmaWr), .iDmaAddr(dmaAddr), .iDmaData(dmaData),
        .oDmaAck(fDmaAck), .oDmaData(fDmaData),
        .oSramAddr(fAddr), .oSramData(fWData), .iSramData(fRd),
        .oSramDir(fDir), .oSramOe(fOe), .oSramWe(fWe), .oSramCe1(fCe), .oBusy(fBusy)
    );

    sram_arbiter #(.ADDR_W(20), .ACCESS_CYCLES(2), .ARB_MODE(1)) u_rr (
        .iClk(clk), .iReset(iReset),
        .iCpuReq(cpuReq), .iCpuWr(cpuWr), .iCpuAddr(cpuAddr), .iCpuData(cpuData),
        .oCpuAck(rCpuAck), .oCpuData(rCpuData),
        .iDmaReq(dmaReq), .iDmaWr(dmaWr), .iDmaAddr(dmaAddr), .iDmaData(dmaData),
        .oDmaAck(rDmaAck), .oDmaData(rDmaData),
        .oSramAddr(rAddr), .oSramData(rWData), .iSramData(rRd),
        .oSramDir(rDir), .oSramOe(rOe), .oSramWe(rWe), .oSramCe1(rCe), .oBusy(rBusy)
    );

    // Async SRAM models: write lands on the rising edge of WE, read is combinational
    assign fRd = memF[fAddr[11:0]];
    assign rRd = memR[rAddr[11:0]];
    always @(posedge fWe) if (iReset === 1'b1) memF[fAddr[11:0]] = fWData;
    always @(posedge rWe) if (iReset === 1'b1) memR[rAddr[11:0]] = rWData;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic invOk(input logic oe, input logic we, input logic dir,
                                   input logic cAck, input logic dAck);
        return !(!oe && !we) && (we || dir) && !(cAck && dAck);
    endfunction

    always @(negedge clk) begin
        if (iReset === 1'b1) begin
            checkOutput("invariant fixed", 32'(invOk(fOe, fWe, fDir, fCpuAck, fDmaAck)), 32'd1);
            checkOutput("invariant rr", 32'(invOk(rOe, rWe, rDir, rCpuAck, rDmaAck)), 32'd1);
        end
    end

    typedef struct {
        logic        cReq, cWr;
        logic [19:0] cAddr;
        logic [7:0]  cData;
        logic        dReq, dWr;
        logic [19:0] dAddr;
        logic [7:0]  dData;
        logic [6:0]  pins;
        logic [19:0] addr;
        logic [7:0]  cRd, dRd;
    } vec_t;

    function automatic vec_t mk(input logic cReq, input logic cWr, input logic [19:0] cAddr,
                                input logic [7:0] cData, input logic dReq, input logic dWr,
                                input logic [19:0] dAddr, input logic [7:0] dData,
                                input logic [6:0] pins, input logic [19:0] addr,
                                input logic [7:0] cRd, input logic [7:0] dRd);
        vec_t v;
        v.cReq = cReq; v.cWr = cWr; v.cAddr = cAddr; v.cData = cData;
        v.dReq = dReq; v.dWr = dWr; v.dAddr = dAddr; v.dData = dData;
        v.pins = pins; v.addr = addr; v.cRd = cRd; v.dRd = dRd;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        cpuReq = v.cReq; cpuWr = v.cWr; cpuAddr = v.cAddr; cpuData = v.cData;
        dmaReq = v.dReq; dmaWr = v.dWr; dmaAddr = v.dAddr; dmaData = v.dData;
    endtask

    task automatic idleInputs();
        cpuReq = 0; cpuWr = 0; cpuAddr = '0; cpuData = '0;
        dmaReq = 0; dmaWr = 0; dmaAddr = '0; dmaData = '0;
    endtask

    int bWho [8];
    int bCyc [8];
    int bN;
    int fCyc [8];
    int fN;

    // Requesters react to the round-robin instance: CPU wants 3 reads, DMA one read from cycle 1
    task automatic runBurst(input bit withDma);
        int cpuAcks = 0;
        int dmaAcks = 0;
        bN = 0;
        fN = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cpuReq = (cpuAcks < 3); cpuWr = 0; cpuAddr = CA;
            dmaReq = withDma && (cyc >= 1) && (dmaAcks < 1); dmaWr = 0; dmaAddr = 20'h00020;
            @(negedge clk);
            if (rCpuAck && bN < 8) begin bWho[bN] = 1; bCyc[bN] = cyc; bN++; cpuAcks++; end
            if (rDmaAck && bN < 8) begin bWho[bN] = 2; bCyc[bN] = cyc; bN++; dmaAcks++; end
            if (fCpuAck && fN < 8) begin fCyc[fN] = cyc; fN++; end
            @(posedge clk); #1;
        end
        idleInputs();
    endtask

    vec_t vecs [20];
    int fSeq [4];
    int rSeq [4];
    int fn, rn, ackCycF, ackCycR, sawDmaAck;
    int expR [4];

    initial begin
        for (int i = 0; i < 4096; i++) begin memF[i] = 8'h00; memR[i] = 8'h00; end
        memF[12'h345] = 8'hA5;
        memR[12'h345] = 8'hA5;

        vecs[0]  = mk(1,0,CA,8'h00,         0,0,20'h0,8'h00, P_IDLE,    20'h0,     8'h00,8'h00);
        vecs[1]  = mk(1,0,CA,8'h00,         0,0,20'h0,8'h00, P_RD,      CA,        8'h00,8'h00);
        vecs[2]  = mk(1,1,20'hFFFFF,8'hEE,  0,0,20'h0,8'h00, P_RD,      CA,        8'h00,8'h00);
        vecs[3]  = mk(1,0,CA,8'h00,         0,0,20'h0,8'h00, P_CDONE_R, CA,        8'hA5,8'h00);
        vecs[4]  = mk(0,0,CA,8'h00,         0,0,20'h0,8'h00, P_IDLE,    CA,        8'hA5,8'h00);
        vecs[5]  = mk(1,1,20'h00010,8'h3C,  0,0,20'h0,8'h00, P_IDLE,    CA,        8'hA5,8'h00);
        vecs[6]  = mk(1,1,20'h00010,8'h3C,  0,0,20'h0,8'h00, P_WSET,    20'h00010, 8'hA5,8'h00);
        vecs[7]  = mk(1,1,20'h00011,8'h00,  0,0,20'h0,8'h00, P_WSTB,    20'h00010, 8'hA5,8'h00);
        vecs[8]  = mk(1,1,20'h00010,8'h3C,  0,0,20'h0,8'h00, P_CDONE_W, 20'h00010, 8'hA5,8'h00);
        vecs[9]  = mk(0,0,20'h0,8'h00,      0,0,20'h0,8'h00, P_IDLE,    20'h00010, 8'hA5,8'h00);
        vecs[10] = mk(0,0,20'h0,8'h00, 1,1,20'h00020,8'h5A,  P_IDLE,    20'h00010, 8'hA5,8'h00);
        vecs[11] = mk(0,0,20'h0,8'h00, 1,1,20'h00020,8'h5A,  P_WSET,    20'h00020, 8'hA5,8'h00);
        vecs[12] = mk(0,0,20'h0,8'h00, 1,1,20'h00020,8'h5A,  P_WSTB,    20'h00020, 8'hA5,8'h00);
        vecs[13] = mk(0,0,20'h0,8'h00, 1,1,20'h00020,8'h5A,  P_DDONE_W, 20'h00020, 8'hA5,8'h00);
        vecs[14] = mk(0,0,20'h0,8'h00, 0,0,20'h0,8'h00,      P_IDLE,    20'h00020, 8'hA5,8'h00);
        vecs[15] = mk(0,0,20'h0,8'h00, 1,0,20'h00020,8'h00,  P_IDLE,    20'h00020, 8'hA5,8'h00);
        vecs[16] = mk(0,0,20'h0,8'h00, 1,0,20'h00020,8'h00,  P_RD,      20'h00020, 8'hA5,8'h00);
        vecs[17] = mk(0,0,20'h0,8'h00, 1,0,20'h00020,8'h00,  P_RD,      20'h00020, 8'hA5,8'h00);
        vecs[18] = mk(0,0,20'h0,8'h00, 1,0,20'h00020,8'h00,  P_DDONE_R, 20'h00020, 8'hA5,8'h5A);
        vecs[19] = mk(0,0,20'h0,8'h00, 0,0,20'h0,8'h00,      P_IDLE,    20'h00020, 8'hA5,8'h5A);

        // Reset held with both requests pending
        idleInputs();
        iReset = 1'b0;
        cpuReq = 1; dmaReq = 1;
        @(negedge clk); @(negedge clk);
        checkOutput("reset pins fixed", 32'(fPins), 32'(P_IDLE));
        checkOutput("reset pins rr", 32'(rPins), 32'(P_IDLE));
        checkOutput("reset addr", 32'(fAddr), 32'h0);
        checkOutput("reset wdata", 32'(fWData), 32'h0);
        checkOutput("reset cpu data", 32'(fCpuData), 32'h0);
        idleInputs();
        @(negedge clk);
        iReset = 1'b1;
        @(posedge clk); #1;

        // Single-port read/write sequences from the table
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d pins", i), 32'(fPins), 32'(vecs[i].pins));
            checkOutput($sformatf("vec%0d pins rr", i), 32'(rPins), 32'(vecs[i].pins));
            checkOutput($sformatf("vec%0d addr", i), 32'(fAddr), 32'(vecs[i].addr));
            checkOutput($sformatf("vec%0d cpuData", i), 32'(fCpuData), 32'(vecs[i].cRd));
            checkOutput($sformatf("vec%0d dmaData", i), 32'(fDmaData), 32'(vecs[i].dRd));
            @(posedge clk); #1;
        end
        idleInputs();
        checkOutput("mem[0x10] fixed", 32'(memF[12'h010]), 32'h3C);
        checkOutput("mem[0x10] rr", 32'(memR[12'h010]), 32'h3C);
        checkOutput("mem[0x20] fixed", 32'(memF[12'h020]), 32'h5A);

        // Both ports requesting continuously for four accesses
        fn = 0; rn = 0;
        cpuReq = 1; cpuWr = 0; cpuAddr = CA;
        dmaReq = 1; dmaWr = 0; dmaAddr = 20'h00020;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (fCpuAck && fn < 4) begin fSeq[fn] = 1; fn++; end
            if (fDmaAck && fn < 4) begin fSeq[fn] = 2; fn++; end
            if (rCpuAck && rn < 4) begin rSeq[rn] = 1; rn++; end
            if (rDmaAck && rn < 4) begin rSeq[rn] = 2; rn++; end
            @(posedge clk); #1;
        end
        idleInputs();
        expR = '{1, 2, 1, 2};
        checkOutput("contend count fixed", 32'(fn), 32'd4);
        checkOutput("contend count rr", 32'(rn), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < fn) checkOutput($sformatf("fixed grant %0d", i), 32'(fSeq[i]), 32'd1);
            if (i < rn) checkOutput($sformatf("rr grant %0d", i), 32'(rSeq[i]), 32'(expR[i]));
        end
        checkOutput("contend rr dmaData", 32'(rDmaData), 32'h5A);

        // Reset during the setup cycle of a DMA write
        dmaReq = 1; dmaWr = 1; dmaAddr = 20'h00030; dmaData = 8'h77;
        @(posedge clk); #3;
        checkOutput("dma write in setup", 32'({rCe, rDir, rWe}), 32'b011);
        iReset = 1'b0;
        #1;
        checkOutput("async reset pins fixed", 32'(fPins), 32'(P_IDLE));
        checkOutput("async reset pins rr", 32'(rPins), 32'(P_IDLE));
        idleInputs();
        sawDmaAck = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fDmaAck || rDmaAck) sawDmaAck = 1;
        end
        checkOutput("no ack after reset", 32'(sawDmaAck), 32'd0);
        checkOutput("reset clears dmaData", 32'(rDmaData), 32'h0);
        iReset = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset", 32'(rPins), 32'(P_IDLE));
        @(posedge clk); #1;
        cpuReq = 1; cpuWr = 0; cpuAddr = CA;
        ackCycF = -1; ackCycR = -1;
        for (int cyc = 0; cyc < 10 && ackCycR < 0; cyc++) begin
            @(negedge clk);
            if (fCpuAck && ackCycF < 0) ackCycF = cyc;
            if (rCpuAck) ackCycR = cyc;
            @(posedge clk); #1;
        end
        idleInputs();
        checkOutput("post-reset read ack fixed", 32'(ackCycF), 32'd3);
        checkOutput("post-reset read ack rr", 32'(ackCycR), 32'd3);
        checkOutput("post-reset read data", 32'(rCpuData), 32'hA5);
        @(posedge clk); #1;

        // Back-to-back CPU reads, then again with a DMA request arriving mid-burst
        runBurst(1'b0);
        checkOutput("burst count rr", 32'(bN), 32'd3);
        checkOutput("burst count fixed", 32'(fN), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < bN) checkOutput($sformatf("burst ack cyc %0d", i), 32'(bCyc[i]), 32'(3 + 4 * i));
            if (i < fN) checkOutput($sformatf("burst fixed cyc %0d", i), 32'(fCyc[i]), 32'(3 + 4 * i));
        end
        @(posedge clk); #1;
        runBurst(1'b1);
        checkOutput("mixed count", 32'(bN), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < bN) begin
                checkOutput($sformatf("mixed who %0d", i), 32'(bWho[i]), (i == 1) ? 32'd2 : 32'd1);
                checkOutput($sformatf("mixed cyc %0d", i), 32'(bCyc[i]), 32'(3 + 4 * i));
            end
        end
        checkOutput("mixed dmaData", 32'(rDmaData), 32'h5A);
        checkOutput("mixed cpuData", 32'(rCpuData), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
